// File: rtl/segasys1_video_timing_pkg.sv
// Shared timing defaults, pixel field layout and colour replication helper
// for the SEGA System 1/2 video path.
package segasys1_pkg;

    localparam int PIX_DIV_DEF  = 8;
    localparam int H_TOTAL_DEF  = 384;
    localparam int H_VIS_DEF    = 256;
    localparam int HS_START_DEF = 304;
    localparam int HS_WIDTH_DEF = 32;
    localparam int V_TOTAL_DEF  = 264;
    localparam int V_VIS_DEF    = 224;
    localparam int VS_START_DEF = 236;
    localparam int VS_WIDTH_DEF = 3;

    localparam int CNT_W = 9;

    // POUT layout is {B[1:0],G[2:0],R[2:0]}
    localparam int R_LSB = 0;
    localparam int G_LSB = 3;
    localparam int B_LSB = 6;

    function automatic logic [7:0] rep3to8(input logic [2:0] x);
        return {x, x, x[2:1]};
    endfunction

endpackage

// File: rtl/segasys1_video_timing_if.sv
// Pixel-domain bundle between the timing generator (master) and the
// system/video consumers (slave).
interface segasys1_video_timing_if;
    import segasys1_pkg::*;

    logic [7:0]       POUT;
    logic [CNT_W-1:0] PH;
    logic [CNT_W-1:0] PV;
    logic             CE_PIX;
    logic             HBLK;
    logic             VBLK;
    logic             HSYNC;
    logic             VSYNC;
    logic             FRAME;
    logic [7:0]       R;
    logic [7:0]       G;
    logic [7:0]       B;

    modport master (
        input  POUT,
        output PH, PV, CE_PIX, HBLK, VBLK, HSYNC, VSYNC, FRAME, R, G, B
    );

    modport slave (
        output POUT,
        input  PH, PV, CE_PIX, HBLK, VBLK, HSYNC, VSYNC, FRAME, R, G, B
    );

endinterface

// File: rtl/segasys1_video_timing_rgb_expand.sv
// 8-bit BBGGGRRR pixel to 24-bit RGB by bit replication, forced to black
// while blanked.
module segasys1_rgb_expand
    import segasys1_pkg::*;
(
    input  logic [7:0] pix_i,
    input  logic       blank_i,
    output logic [7:0] r_o,
    output logic [7:0] g_o,
    output logic [7:0] b_o
);

    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;

    always_comb begin
        r   = pix_i[R_LSB +: 3];
        g   = pix_i[G_LSB +: 3];
        b   = pix_i[B_LSB +: 2];
        r_o = '0;
        g_o = '0;
        b_o = '0;
        if (!blank_i) begin
            r_o = rep3to8(r);
            g_o = rep3to8(g);
            b_o = {b, b, b, b};
        end
    end

endmodule

// File: rtl/segasys1_video_timing.sv
// Raster timing generator (pixel divider, PH/PV counters, sync/blank decode)
// plus the one-pixel output pipeline feeding the RGB expander.
module segasys1_video_timing
    import segasys1_pkg::*;
#(
    parameter int PIX_DIV  = PIX_DIV_DEF,
    parameter int H_TOTAL  = H_TOTAL_DEF,
    parameter int H_VIS    = H_VIS_DEF,
    parameter int HS_START = HS_START_DEF,
    parameter int HS_WIDTH = HS_WIDTH_DEF,
    parameter int V_TOTAL  = V_TOTAL_DEF,
    parameter int V_VIS    = V_VIS_DEF,
    parameter int VS_START = VS_START_DEF,
    parameter int VS_WIDTH = VS_WIDTH_DEF
)(
    input  logic                    clk48M,
    input  logic                    reset_n,
    segasys1_video_timing_if.master vid
);

    localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VIS);
    // Sync windows compared one bit wider so an end of exactly 512 still fits
    localparam logic [CNT_W:0]   HS_LO    = (CNT_W+1)'(HS_START);
    localparam logic [CNT_W:0]   HS_HI    = (CNT_W+1)'(HS_START + HS_WIDTH);
    localparam logic [CNT_W:0]   VS_LO    = (CNT_W+1)'(VS_START);
    localparam logic [CNT_W:0]   VS_HI    = (CNT_W+1)'(VS_START + VS_WIDTH);

    if (PIX_DIV < 2 || H_VIS >= HS_START || HS_START + HS_WIDTH > H_TOTAL ||
        V_VIS >= VS_START || VS_START + VS_WIDTH > V_TOTAL ||
        H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_param_check
        $error("segasys1_video_timing: illegal timing parameters");
    end

    logic [DIV_W-1:0] div_q, div_d;
    logic             ce_q, ce_d;
    logic             frame_q, frame_d;
    logic [CNT_W-1:0] ph_q, ph_d;
    logic [CNT_W-1:0] pv_q, pv_d;
    logic [7:0]       pix_q;
    logic             hb_q, vb_q, hs_q, vs_q;
    logic             hb, vb, hs, vs;

    always_comb begin
        ce_d    = (div_q == DIV_LAST);
        div_d   = ce_d ? '0 : div_q + 1'b1;
        // ce_d and ce_q never coincide, so PH/PV are stable when FRAME is decided
        frame_d = ce_d && (ph_q == '0) && (pv_q == '0);
        ph_d    = ph_q;
        pv_d    = pv_q;
        if (ce_q) begin
            if (ph_q == H_LAST) begin
                ph_d = '0;
                pv_d = (pv_q == V_LAST) ? '0 : pv_q + 1'b1;
            end else begin
                ph_d = ph_q + 1'b1;
            end
        end
        hb = (ph_q >= H_VIS_C);
        vb = (pv_q >= V_VIS_C);
        hs = ({1'b0, ph_q} >= HS_LO) && ({1'b0, ph_q} < HS_HI);
        vs = ({1'b0, pv_q} >= VS_LO) && ({1'b0, pv_q} < VS_HI);
    end

    always_ff @(posedge clk48M or negedge reset_n) begin
        if (!reset_n) begin
            div_q   <= '0;
            ce_q    <= 1'b0;
            frame_q <= 1'b0;
            ph_q    <= '0;
            pv_q    <= '0;
            pix_q   <= '0;
            hb_q    <= 1'b0;
            vb_q    <= 1'b0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
        end else begin
            div_q   <= div_d;
            ce_q    <= ce_d;
            frame_q <= frame_d;
            ph_q    <= ph_d;
            pv_q    <= pv_d;
            if (ce_q) begin
                pix_q <= vid.POUT;
                hb_q  <= hb;
                vb_q  <= vb;
                hs_q  <= hs;
                vs_q  <= vs;
            end
        end
    end

    assign vid.PH     = ph_q;
    assign vid.PV     = pv_q;
    assign vid.CE_PIX = ce_q;
    assign vid.FRAME  = frame_q;
    assign vid.HBLK   = hb_q;
    assign vid.VBLK   = vb_q;
    assign vid.HSYNC  = hs_q;
    assign vid.VSYNC  = vs_q;

    segasys1_rgb_expand u_rgb (
        .pix_i   (pix_q),
        .blank_i (hb_q | vb_q),
        .r_o     (vid.R),
        .g_o     (vid.G),
        .b_o     (vid.B)
    );

endmodule
